top_entity: RTL and testbench

- Hardware runtime monitor for a fixed stream specification over two boolean inputs `a`, `b` and one signed 64-bit input `id`.
- A high-level controller (HLC) samples input events and the periodic deadline once per monitor cycle; a low-level controller (LLC) evaluates the output streams over 5 clock stages.
- The monitor therefore runs at 1/5 of the clock rate.
- The block sits at the top of the generated monitor and drives verdicts plus HLC/LLC debug taps.

---
 rtl/top_entity.sv | 140 ++++++++++++++
 tb/tb_top_entity.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_entity.sv
// Runtime monitor: HLC samples inputs once per 5-clock monitor cycle, LLC evaluates streams in stages 1-3.
// Verdicts and _aktv flags load at the stage-4 edge and hold for the following monitor cycle.
module top_entity #(
  parameter int TIME_PERIOD = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               input_a,
  input  logic               new_input_a,
  input  logic               input_b,
  input  logic               new_input_b,
  input  logic signed [63:0] input_id,
  input  logic               new_input_id,
  output logic               hlc_clock,
  output logic signed [63:0] hlc_clock_cnt,
  output logic               hlc_a,
  output logic               hlc_b,
  output logic signed [63:0] hlc_id,
  output logic               hlc_en_lt,
  output logic               hlc_en_gt,
  output logic               hlc_en_neq,
  output logic               hlc_en_not_a,
  output logic               hlc_en_a_impl_b,
  output logic               hlc_en_time_stream,
  output logic signed [63:0] llc_stage,
  output logic               output_lt,
  output logic               output_gt,
  output logic               output_neq,
  output logic               output_not_a,
  output logic               output_a_impl_b,
  output logic signed [63:0] output_time_stream,
  output logic               output_lt_aktv,
  output logic               output_gt_aktv,
  output logic               output_neq_aktv,
  output logic               output_not_a_aktv,
  output logic               output_a_impl_b_aktv,
  output logic               output_time_stream_aktv
);

  localparam logic [31:0] PERIOD_LAST = 32'(TIME_PERIOD - 1);

  logic [2:0]         stage;
  logic [31:0]        period_cnt;
  logic               eval_lt;
  logic               eval_gt;
  logic               eval_neq;
  logic               eval_not_a;
  logic               eval_a_impl_b;
  logic signed [63:0] eval_time_stream;

  assign hlc_clock = (stage == 3'd0) & en;
  assign llc_stage = {61'd0, stage};

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage                   <= 3'd0;
      period_cnt              <= '0;
      hlc_clock_cnt           <= '0;
      hlc_a                   <= 1'b0;
      hlc_b                   <= 1'b0;
      hlc_id                  <= '0;
      hlc_en_lt               <= 1'b0;
      hlc_en_gt               <= 1'b0;
      hlc_en_neq              <= 1'b0;
      hlc_en_not_a            <= 1'b0;
      hlc_en_a_impl_b         <= 1'b0;
      hlc_en_time_stream      <= 1'b0;
      eval_lt                 <= 1'b0;
      eval_gt                 <= 1'b0;
      eval_neq                <= 1'b0;
      eval_not_a              <= 1'b0;
      eval_a_impl_b           <= 1'b0;
      eval_time_stream        <= '0;
      output_lt               <= 1'b0;
      output_gt               <= 1'b0;
      output_neq              <= 1'b0;
      output_not_a            <= 1'b0;
      output_a_impl_b         <= 1'b0;
      output_time_stream      <= '0;
      output_lt_aktv          <= 1'b0;
      output_gt_aktv          <= 1'b0;
      output_neq_aktv         <= 1'b0;
      output_not_a_aktv       <= 1'b0;
      output_a_impl_b_aktv    <= 1'b0;
      output_time_stream_aktv <= 1'b0;
    end else if (en) begin
      stage <= (stage == 3'd4) ? 3'd0 : stage + 3'd1;
      case (stage)
        3'd0: begin
          if (new_input_a)  hlc_a  <= input_a;
          if (new_input_b)  hlc_b  <= input_b;
          if (new_input_id) hlc_id <= input_id;
          hlc_en_lt       <= new_input_id;
          hlc_en_gt       <= new_input_id;
          hlc_en_not_a    <= new_input_a;
          hlc_en_neq      <= new_input_a & new_input_b;
          hlc_en_a_impl_b <= new_input_a & new_input_b;
          hlc_clock_cnt   <= hlc_clock_cnt + 64'sd1;
          // Deadline fires on the monitor cycle that completes each period.
          if (period_cnt == PERIOD_LAST) begin
            period_cnt         <= '0;
            hlc_en_time_stream <= 1'b1;
          end else begin
            period_cnt         <= period_cnt + 32'd1;
            hlc_en_time_stream <= 1'b0;
          end
        end
        3'd1: begin
          eval_lt <= hlc_id < 64'sd3;
          eval_gt <= hlc_id > 64'sd3;
        end
        3'd2: begin
          eval_neq      <= hlc_a ^ hlc_b;
          eval_not_a    <= ~hlc_a;
          eval_a_impl_b <= ~hlc_a | hlc_b;
        end
        3'd3: begin
          eval_time_stream <= output_time_stream + 64'sd1;
        end
        3'd4: begin
          if (hlc_en_lt)          output_lt          <= eval_lt;
          if (hlc_en_gt)          output_gt          <= eval_gt;
          if (hlc_en_neq)         output_neq         <= eval_neq;
          if (hlc_en_not_a)       output_not_a       <= eval_not_a;
          if (hlc_en_a_impl_b)    output_a_impl_b    <= eval_a_impl_b;
          if (hlc_en_time_stream) output_time_stream <= eval_time_stream;
          output_lt_aktv          <= hlc_en_lt;
          output_gt_aktv          <= hlc_en_gt;
          output_neq_aktv         <= hlc_en_neq;
          output_not_a_aktv       <= hlc_en_not_a;
          output_a_impl_b_aktv    <= hlc_en_a_impl_b;
          output_time_stream_aktv <= hlc_en_time_stream;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_entity.sv
// Randomized and directed bench for top_entity against a monitor-level reference model.
module tb_top_entity;
  localparam int TP = 10;

  logic clk = 1'b0;
  logic rst, en;
  logic input_a, new_input_a, input_b, new_input_b, new_input_id;
  logic signed [63:0] input_id;
  logic hlc_clock, hlc_a, hlc_b;
  logic signed [63:0] hlc_clock_cnt, hlc_id, llc_stage, output_time_stream;
  logic hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream;
  logic output_lt, output_gt, output_neq, output_not_a, output_a_impl_b;
  logic output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv;
  logic output_a_impl_b_aktv, output_time_stream_aktv;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (monitor-level view)
  logic [2:0] m_stage;
  longint m_cnt, m_id, o_ts;
  logic m_a, m_b;
  logic e_lt, e_gt, e_neq, e_not_a, e_impl, e_ts;
  logic o_lt, o_gt, o_neq, o_not_a, o_impl;
  logic k_lt, k_gt, k_neq, k_not_a, k_impl, k_ts;

  logic [275:0] obs_vec, exp_vec;

  top_entity #(.TIME_PERIOD(TP)) dut (
    .clk(clk), .rst(rst), .en(en),
    .input_a(input_a), .new_input_a(new_input_a),
    .input_b(input_b), .new_input_b(new_input_b),
    .input_id(input_id), .new_input_id(new_input_id),
    .hlc_clock(hlc_clock), .hlc_clock_cnt(hlc_clock_cnt),
    .hlc_a(hlc_a), .hlc_b(hlc_b), .hlc_id(hlc_id),
    .hlc_en_lt(hlc_en_lt), .hlc_en_gt(hlc_en_gt), .hlc_en_neq(hlc_en_neq),
    .hlc_en_not_a(hlc_en_not_a), .hlc_en_a_impl_b(hlc_en_a_impl_b),
    .hlc_en_time_stream(hlc_en_time_stream), .llc_stage(llc_stage),
    .output_lt(output_lt), .output_gt(output_gt), .output_neq(output_neq),
    .output_not_a(output_not_a), .output_a_impl_b(output_a_impl_b),
    .output_time_stream(output_time_stream),
    .output_lt_aktv(output_lt_aktv), .output_gt_aktv(output_gt_aktv),
    .output_neq_aktv(output_neq_aktv), .output_not_a_aktv(output_not_a_aktv),
    .output_a_impl_b_aktv(output_a_impl_b_aktv),
    .output_time_stream_aktv(output_time_stream_aktv)
  );

  always #5 clk = ~clk;

  assign obs_vec = {hlc_clock_cnt, hlc_a, hlc_b, hlc_id,
                    hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream,
                    llc_stage,
                    output_lt, output_gt, output_neq, output_not_a, output_a_impl_b,
                    output_time_stream,
                    output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv,
                    output_a_impl_b_aktv, output_time_stream_aktv, hlc_clock};
  assign exp_vec = {m_cnt, m_a, m_b, m_id,
                    e_lt, e_gt, e_neq, e_not_a, e_impl, e_ts,
                    {61'd0, m_stage},
                    o_lt, o_gt, o_neq, o_not_a, o_impl,
                    o_ts,
                    k_lt, k_gt, k_neq, k_not_a, k_impl, k_ts,
                    (m_stage == 3'd0) && en};

  // Advance the model by one clock using the inputs currently driven, then let the DUT take the edge.
  task automatic step();
    if (!rst) begin
      m_stage = 0; m_cnt = 0; m_id = 0; o_ts = 0; m_a = 0; m_b = 0;
      {e_lt, e_gt, e_neq, e_not_a, e_impl, e_ts} = '0;
      {o_lt, o_gt, o_neq, o_not_a, o_impl} = '0;
      {k_lt, k_gt, k_neq, k_not_a, k_impl, k_ts} = '0;
    end else if (en) begin
      if (m_stage == 0) begin
        if (new_input_a)  m_a = input_a;
        if (new_input_b)  m_b = input_b;
        if (new_input_id) m_id = input_id;
        m_cnt   = m_cnt + 1;
        e_lt    = new_input_id;
        e_gt    = new_input_id;
        e_not_a = new_input_a;
        e_neq   = new_input_a && new_input_b;
        e_impl  = new_input_a && new_input_b;
        e_ts    = (m_cnt % TP) == 0;
      end
      if (m_stage == 4) begin
        if (e_lt)    o_lt    = m_id < 3;
        if (e_gt)    o_gt    = m_id > 3;
        if (e_neq)   o_neq   = m_a != m_b;
        if (e_not_a) o_not_a = !m_a;
        if (e_impl)  o_impl  = !m_a || m_b;
        if (e_ts)    o_ts    = o_ts + 1;
        {k_lt, k_gt, k_neq, k_not_a, k_impl, k_ts} = {e_lt, e_gt, e_neq, e_not_a, e_impl, e_ts};
      end
      m_stage = (m_stage == 4) ? 3'd0 : m_stage + 3'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic b, input longint id,
                       input logic na, input logic nb, input logic nid);
    input_a = a; input_b = b; input_id = id;
    new_input_a = na; new_input_b = nb; new_input_id = nid;
  endtask

  task automatic go_to_stage(input int s);
    for (int i = 0; i < 6 && m_stage != s; i++) step();
  endtask

  task automatic test_reset();
    rst = 0; en = 0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL reset obs=%h exp=%h", obs_vec, exp_vec); end
    rst = 1; en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_err++; $display("FAIL idle cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
    end
    n_vec++;
    if (hlc_clock_cnt !== 64'sd2) begin n_err++; $display("FAIL idle_clock_cnt got=%0d want=2", hlc_clock_cnt); end
  endtask

  task automatic test_all_strobes();
    go_to_stage(0);
    drive(1, 1, 2, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_err++; $display("FAIL ev1 cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
    end
    n_vec++;
    if ({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b} !== 5'b10001) begin
      n_err++; $display("FAIL ev1_verdicts got=%b want=10001",
                        {output_lt, output_gt, output_neq, output_not_a, output_a_impl_b});
    end
    n_vec++;
    if ({output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv,
         output_time_stream_aktv} !== 6'b111110) begin
      n_err++; $display("FAIL ev1_aktv got=%b want=111110", {output_lt_aktv, output_gt_aktv,
                        output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv, output_time_stream_aktv});
    end
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if ({output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv,
         output_time_stream_aktv} !== 6'b000000) begin
      n_err++; $display("FAIL ev1_aktv_drop got=%b want=000000", {output_lt_aktv, output_gt_aktv,
                        output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv, output_time_stream_aktv});
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL ev1_drop obs=%h exp=%h", obs_vec, exp_vec); end
  endtask

  task automatic test_boundary_id();
    go_to_stage(0);
    drive(1, 0, 3, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if ({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b,
         output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv}
        !== 10'b00100_11111) begin
      n_err++; $display("FAIL ev2 got=%b want=0010011111", {output_lt, output_gt, output_neq,
                        output_not_a, output_a_impl_b, output_lt_aktv, output_gt_aktv,
                        output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv});
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL ev2_model obs=%h exp=%h", obs_vec, exp_vec); end
  endtask

  task automatic test_partial_strobes();
    go_to_stage(0);
    drive(0, 1, 4, 1, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if ({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b} !== 5'b01110) begin
      n_err++; $display("FAIL ev3_verdicts got=%b want=01110",
                        {output_lt, output_gt, output_neq, output_not_a, output_a_impl_b});
    end
    n_vec++;
    if ({output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv}
        !== 5'b11010) begin
      n_err++; $display("FAIL ev3_aktv got=%b want=11010", {output_lt_aktv, output_gt_aktv,
                        output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv});
    end
    n_vec++;
    if (hlc_b !== 1'b0) begin n_err++; $display("FAIL ev3_hlc_b got=%b want=0", hlc_b); end
  endtask

  task automatic test_stage_filter();
    go_to_stage(2);
    drive(0, 0, -5, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    go_to_stage(0);
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (output_lt_aktv !== 1'b0 || hlc_id !== 64'sd4) begin
      n_err++; $display("FAIL late_strobe got aktv=%b id=%0d want aktv=0 id=4", output_lt_aktv, hlc_id);
    end
    drive(0, 0, -5, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if ({output_lt, output_gt, output_lt_aktv} !== 3'b101) begin
      n_err++; $display("FAIL neg_id got=%b want=101", {output_lt, output_gt, output_lt_aktv});
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL neg_id_model obs=%h exp=%h", obs_vec, exp_vec); end
  endtask

  task automatic test_time_stream();
    longint prev_ts;
    logic prev_aktv;
    prev_ts = o_ts;
    prev_aktv = 1'b0;
    for (int i = 0; i < 2 * TP * 5 + 20; i++) begin
      en = !(i inside {37, 38, 39, 71});
      step();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_err++; $display("FAIL time cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
      if (output_time_stream_aktv === 1'b1 && !prev_aktv) begin
        n_vec++;
        if (output_time_stream !== prev_ts + 1) begin
          n_err++; $display("FAIL time_inc got=%0d want=%0d", output_time_stream, prev_ts + 1);
        end
        prev_ts = prev_ts + 1;
      end
      prev_aktv = output_time_stream_aktv;
    end
    en = 1;
    n_vec++;
    if (prev_ts < 2) begin n_err++; $display("FAIL time_pulses got=%0d want>=2", prev_ts); end
  endtask

  task automatic test_reset_mid();
    go_to_stage(0);
    drive(1, 1, 0, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    step();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rst_mid cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
    end
    n_vec++;
    if ({output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv,
         output_lt, output_a_impl_b} !== 7'b0) begin
      n_err++; $display("FAIL rst_mid_abort got=%b want=0", {output_lt_aktv, output_gt_aktv,
                        output_neq_aktv, output_not_a_aktv, output_a_impl_b_aktv, output_lt, output_a_impl_b});
    end
  endtask

  task automatic test_random();
    int tmp;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 7) != 0);
      input_a = 1'($urandom); input_b = 1'($urandom);
      new_input_a = 1'($urandom); new_input_b = 1'($urandom); new_input_id = 1'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        tmp = int'($urandom_range(0, 10)) - 5;
        input_id = tmp;
      end else begin
        input_id = {$urandom, $urandom};
      end
      step();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_err++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec); end
    end
    rst = 1; en = 1;
  endtask

  initial begin
    rst = 0; en = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_all_strobes();
    test_boundary_id();
    test_partial_strobes();
    test_stage_filter();
    test_time_stream();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
